// File: rtl/accum_ovf_pkg.sv
// Shared definitions for the overflow-tracking frame accumulator.
//   state_t     : FSM state encoding (IDLE, ACCUM, DONE)
//   COUNT_MAX   : saturation ceiling of the 8-bit overflow event counter
//   sat_max/min : two's-complement limits for a given width. They are returned
//                 as 64-bit patterns; callers keep the low WIDTH bits.
package accum_ovf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int unsigned MAX_WIDTH = 64;
  localparam logic [7:0]  COUNT_MAX = 8'hFF;

  // Largest positive value, 2^(width-1)-1.
  function automatic logic [MAX_WIDTH-1:0] sat_max(input int unsigned width);
    sat_max = (64'(1) << (width - 1)) - 64'(1);
  endfunction

  // Most negative value, -2^(width-1). Its low width bits are 100..0.
  function automatic logic [MAX_WIDTH-1:0] sat_min(input int unsigned width);
    sat_min = ~sat_max(width);
  endfunction

endpackage

// File: rtl/ovf_sat_add.sv
// Combinational signed adder with overflow detection and optional clamp.
//   a, b : WIDTH-bit two's-complement operands
//   sum  : a+b. On overflow this is the clamped limit when SATURATE=1,
//          or the wrapped low WIDTH bits when SATURATE=0.
//   ovf  : signed overflow. It is set when both operands have the same sign
//          and the result sign differs from it.
module ovf_sat_add
  import accum_ovf_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter bit          SATURATE = 1'b1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] MIN_VAL = WIDTH'(sat_min(WIDTH));

  logic [WIDTH:0] sum_ext;

  always_comb begin
    sum_ext = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    // The top two bits of the sign-extended sum disagree exactly when the
    // operand signs match and the result sign differs from them.
    ovf     = sum_ext[WIDTH] != sum_ext[WIDTH-1];
    sum     = sum_ext[WIDTH-1:0];
    if (ovf && SATURATE) begin
      sum = a[WIDTH-1] ? MIN_VAL : MAX_VAL;
    end
  end

endmodule

// File: rtl/accum_ovf_src.sv
// Frame accumulator that reports overflow events to a downstream sticky flag.
//   start      : begins a frame when the block is idle
//   in_valid   : qualifies in_data during a frame
//   in_data    : signed sample
//   clr_req    : requests a clear of the downstream sticky flag and ovf_count
//   acc_out    : final frame result, held until a later frame completes
//   out_valid  : one-cycle pulse in the DONE state
//   busy       : high during ACCUM and DONE
//   ovf_set    : one-cycle pulse, one cycle after an overflowing sample
//   ovf_clr    : one-cycle pulse, one cycle after clr_req
//   ovf_count  : overflow events since the last clear, saturating at 255
module accum_ovf_src
  import accum_ovf_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned FRAME_LEN = 8,
  parameter bit          SATURATE  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clr_req,
  output logic [WIDTH-1:0] acc_out,
  output logic             out_valid,
  output logic             busy,
  output logic             ovf_set,
  output logic             ovf_clr,
  output logic [7:0]       ovf_count
);

  state_t           state, state_next;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] add_sum;
  logic             add_ovf;
  logic [7:0]       sample_cnt;
  logic             accept;
  logic             last_sample;
  logic             ovf_event;

  ovf_sat_add #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_add (
    .a   (acc),
    .b   (in_data),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  assign accept      = (state == ST_ACCUM) && in_valid;
  assign last_sample = sample_cnt == 8'(FRAME_LEN - 1);
  assign ovf_event   = accept && add_ovf;

  // NOTE: every output of this block gets a default before the case statement.
  // Without the defaults, a path that skips an assignment would infer a latch.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_ACCUM;
      end
      ST_ACCUM: begin
        busy = 1'b1;
        if (accept && last_sample) state_next = ST_DONE;
      end
      ST_DONE: begin
        busy       = 1'b1;
        out_valid  = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments. All registers then
  // sample their inputs at the same edge, whatever order the blocks run in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      sample_cnt <= '0;
      acc_out    <= '0;
    end else if (state == ST_IDLE && start) begin
      acc        <= '0;
      sample_cnt <= '0;
    end else if (accept) begin
      acc        <= add_sum;
      sample_cnt <= sample_cnt + 8'd1;
      // Capture the result on the last sample so that it is valid in DONE.
      if (last_sample) acc_out <= add_sum;
    end
  end

  // The overflow reporting logic runs in every state and is independent of the
  // FSM. A clear in the same cycle as an overflow leaves the count at 1, so the
  // set dominates downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_set   <= 1'b0;
      ovf_clr   <= 1'b0;
      ovf_count <= '0;
    end else begin
      ovf_set <= ovf_event;
      ovf_clr <= clr_req;
      if (clr_req)                                   ovf_count <= ovf_event ? 8'd1 : 8'd0;
      else if (ovf_event && ovf_count != COUNT_MAX)  ovf_count <= ovf_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_accum_ovf_src.sv
// Self-checking bench for accum_ovf_src (WIDTH=16, FRAME_LEN=8, SATURATE=1).
// A table of frames is driven in a loop. Each frame's expected result goes
// onto a scoreboard queue at start, and a negedge monitor pops the entry when
// out_valid appears. Hand-written sequences cover the multi-cycle corner cases.
module tb_accum_ovf_src;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [15:0] in_data;
  logic        clr_req;
  logic [15:0] acc_out;
  logic        out_valid;
  logic        busy;
  logic        ovf_set;
  logic        ovf_clr;
  logic [7:0]  ovf_count;

  accum_ovf_src #(
    .WIDTH     (16),
    .FRAME_LEN (8),
    .SATURATE  (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .clr_req   (clr_req),
    .acc_out   (acc_out),
    .out_valid (out_valid),
    .busy      (busy),
    .ovf_set   (ovf_set),
    .ovf_clr   (ovf_clr),
    .ovf_count (ovf_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [0:7][15:0] s;
    bit               gap;
    logic [15:0]      acc;
    int               pulses;
    bit               last_ovf;
  } vec_t;

  typedef struct {
    logic [15:0] acc;
    int          pulses;
    int          count;
  } exp_t;

  vec_t vecs[6];
  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ovf_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int i, input logic [0:7][15:0] s, input bit gap,
                      input logic [15:0] acc, input int pulses, input bit last_ovf);
    vecs[i].s        = s;
    vecs[i].gap      = gap;
    vecs[i].acc      = acc;
    vecs[i].pulses   = pulses;
    vecs[i].last_ovf = last_ovf;
  endtask

  // Drives one complete frame. The expectation is queued for the monitor, and
  // the DONE cycle and the return to IDLE are checked inline. clr_at selects a
  // sample that carries clr_req in the same cycle; -1 means none.
  task automatic run_frame(input logic [0:7][15:0] s, input bit gap,
                           input logic [15:0] exp_acc, input int exp_pulses,
                           input int exp_count, input bit clr_first,
                           input int clr_at, input bit last_ovf);
    exp_t e;
    if (clr_first) begin
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
    end
    e.acc = exp_acc; e.pulses = exp_pulses; e.count = exp_count;
    exp_q.push_back(e);
    ovf_seen = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    for (int i = 0; i < 8; i++) begin
      if (gap) begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        start    = 1'b1;              // must be ignored in ACCUM
        step();
        start    = 1'b0;
      end
      in_valid = 1'b1;
      in_data  = s[i];
      clr_req  = (i == clr_at);
      step();
      in_valid = 1'b0;
      clr_req  = 1'b0;
      if (i == clr_at) begin
        check("same_cycle_ovf_set", ovf_set, 1);
        check("same_cycle_ovf_clr", ovf_clr, 1);
        check("same_cycle_ovf_count", ovf_count, 1);
      end
    end
    // The DONE cycle follows the 8th accepted sample directly.
    check("done_out_valid", out_valid, 1);
    check("done_busy", busy, 1);
    check("done_acc_out", acc_out, exp_acc);
    check("done_ovf_set", ovf_set, last_ovf);
    if (gap) start = 1'b1;            // must be ignored in DONE
    step();
    start = 1'b0;
    check("idle_out_valid", out_valid, 0);
    check("idle_busy", busy, 0);
    check("idle_acc_hold", acc_out, exp_acc);
  endtask

  // Scoreboard monitor: counts ovf_set pulses and checks each frame result.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ovf_set) ovf_seen++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out_valid: got out_valid=1, required no pending frame");
        end else begin
          mon_e = exp_q.pop_front();
          check("frame_acc_out", acc_out, mon_e.acc);
          check("frame_ovf_pulses", ovf_seen, mon_e.pulses);
          check("frame_ovf_count", ovf_count, mon_e.count);
        end
      end
    end
  end

  initial begin
    logic [0:7][15:0] s;
    load(0, {8{16'h1000}}, 1'b0, 16'h7FFF, 1, 1'b1);
    load(1, {16'h8000, 16'hFFFF, {6{16'h0000}}}, 1'b0, 16'h8000, 1, 1'b0);
    load(2, {8{16'h0001}}, 1'b1, 16'h0008, 0, 1'b0);
    load(3, {8{16'hF000}}, 1'b0, 16'h8000, 0, 1'b0);
    load(4, {16'h7FFF, 16'h0001, 16'hFFFF, {5{16'h0000}}}, 1'b0, 16'h7FFE, 1, 1'b0);
    load(5, {16'h4000, 16'h4000, 16'h8000, 16'h8000, 16'h7FFF, {3{16'h0000}}},
         1'b0, 16'hFFFF, 2, 1'b0);

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; clr_req = 1'b0;
    #12;
    check("rst_acc_out", acc_out, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf_set", ovf_set, 0);
    check("rst_ovf_clr", ovf_clr, 0);
    check("rst_ovf_count", ovf_count, 0);
    step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++)
      run_frame(vecs[i].s, vecs[i].gap, vecs[i].acc, vecs[i].pulses,
                vecs[i].pulses, 1'b1, -1, vecs[i].last_ovf);

    // clr_req arrives together with an overflowing sample.
    s = {16'h7FFF, 16'h0001, {6{16'h0000}}};
    run_frame(s, 1'b0, 16'h7FFF, 1, 1, 1'b0, 1, 1'b0);

    // Reset after the 4th sample abandons the frame at once, with no out_valid.
    clr_req = 1'b1; step(); clr_req = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 16'h1000; step();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_acc_out", acc_out, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ovf_count", ovf_count, 0);
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_idle_busy", busy, 0);
    end
    run_frame(vecs[0].s, 1'b0, 16'h7FFF, 1, 1, 1'b1, -1, 1'b1);

    // 43 frames of 0x4000 give 7 overflows each (301 events), so the count saturates.
    for (int k = 1; k <= 43; k++)
      run_frame({8{16'h4000}}, 1'b0, 16'h7FFF, 7, (7 * k > 255) ? 255 : 7 * k,
                k == 1, -1, 1'b1);
    check("sat_ovf_count", ovf_count, 255);
    clr_req = 1'b1; step(); clr_req = 1'b0;
    check("sat_clr_pulse", ovf_clr, 1);
    check("sat_clr_count", ovf_count, 0);
    step();
    check("sat_clr_single", ovf_clr, 0);

    step();
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/accum_ovf_src.md
ACCUM_OVF_SRC -- requirements
Module: accum_ovf_src

Interface
REQ-001 SHALL have parameter WIDTH, default 16, sample and accumulator width in bits, two's complement.
REQ-002 SHALL have parameter FRAME_LEN, default 8, accepted samples per frame, range 1..255.
REQ-003 SHALL have parameter SATURATE, default 1: 1 clamps on overflow, 0 wraps.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  begin a frame.
REQ-007 SHALL have port in_valid  input  1  in_data is valid this cycle.
REQ-008 SHALL have port in_data  input  WIDTH  signed sample.
REQ-009 SHALL have port clr_req  input  1  request to clear the downstream sticky overflow flag.
REQ-010 SHALL have port acc_out  output  WIDTH  frame result.
REQ-011 SHALL have port out_valid  output  1  one-cycle pulse: acc_out holds the final frame result.
REQ-012 SHALL have port busy  output  1  high while a frame is in progress.
REQ-013 SHALL have port ovf_set  output  1  one-cycle overflow event pulse, drives the sticky flag set input.
REQ-014 SHALL have port ovf_clr  output  1  one-cycle clear pulse, drives the sticky flag reset input.
REQ-015 SHALL have port ovf_count  output  8  overflow events since the last clear, saturating.

Function
REQ-016 SHALL implement states IDLE, ACCUM and DONE.
REQ-017 IDLE: on start, SHALL clear the accumulator and sample counter and go to ACCUM; in_valid is ignored in IDLE.
REQ-018 ACCUM: each cycle with in_valid high SHALL accept one sample, computing a WIDTH+1-bit sum of acc and in_data; start is ignored in ACCUM.
REQ-019 Signed overflow SHALL be flagged when the operand signs are equal and the result sign differs.
REQ-020 On overflow with SATURATE=1, acc SHALL take the maximum positive value (2^(WIDTH-1)-1) or the minimum negative value (-2^(WIDTH-1)), matching the operand sign; with SATURATE=0 it SHALL take the low WIDTH bits.
REQ-021 ovf_set SHALL pulse high for exactly one cycle, in the cycle after each overflowing accepted sample.
REQ-022 After the FRAME_LEN-th accepted sample the FSM SHALL enter DONE for one cycle, assert out_valid, then return to IDLE; start is ignored in DONE.
REQ-023 acc_out SHALL hold the final result from DONE until the next start.
REQ-024 busy SHALL be high in ACCUM and DONE and low in IDLE.
REQ-025 ovf_clr SHALL pulse for one cycle, in the cycle after clr_req is high; ovf_count SHALL clear to 0 at the same edge.
REQ-026 If an overflow and clr_req occur in the same cycle, ovf_set and ovf_clr SHALL both assert in the next cycle and ovf_count SHALL become 1, so the set dominates downstream.
REQ-027 ovf_count SHALL increment on each overflow and saturate at 255.
REQ-028 clr_req SHALL be honoured in every state and SHALL NOT affect the accumulator or the FSM.

Reset
REQ-029 While rst_n is low: state IDLE, accumulator 0, counters 0; acc_out, out_valid, busy, ovf_set, ovf_clr and ovf_count all 0, applied immediately without a clock edge.
REQ-030 Reset asserted mid-frame SHALL abandon the frame with no out_valid; after release the block SHALL wait in IDLE for start.

Structure
REQ-031 A shared package accum_ovf_pkg SHALL hold the state encoding and the WIDTH-dependent saturation limit constants.
REQ-032 Signed add, overflow detect and clamp SHALL be one combinational sub-module, ovf_sat_add; the FSM and counters stay in accum_ovf_src.

Verification (WIDTH=16, FRAME_LEN=8, SATURATE=1)
REQ-033 Eight samples of 0x1000 -> acc_out=0x7FFF; out_valid pulses once; exactly one ovf_set, one cycle after the 8th sample; ovf_count=1.
REQ-034 Samples 0x8000 then 0xFFFF, then six zeros -> acc_out=0x8000, one ovf_set, ovf_count=1.
REQ-035 Eight samples of 0x0001 with in_valid low on alternate cycles -> acc_out=0x0008; out_valid exactly one cycle after the 8th accepted sample; no ovf_set.
REQ-036 clr_req in the same cycle as an overflowing sample -> ovf_set=ovf_clr=1 in the next cycle, ovf_count=1.
REQ-037 rst_n low after the 4th sample of a frame -> all outputs 0 at once; no out_valid; a new start then runs a clean frame.
REQ-038 300 overflow events with no clr_req -> ovf_count=255; one clr_req -> ovf_count=0 and one ovf_clr pulse.
